// File: rtl/immgen_pipe_if.sv
// Handshake bundle for immgen_pipe: producer side (instr/pc in) and consumer side
// (decoded immediate out). The master modport belongs to whoever drives instructions
// and consumes results; the slave modport belongs to the generator.
interface immgen_pipe_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] target;
  logic [2:0]      fmt;
  logic            illegal;

  modport master (
    output in_valid, instr, pc, flush, out_ready,
    input  in_ready, out_valid, imm, target, fmt, illegal
  );

  modport slave (
    input  in_valid, instr, pc, flush, out_ready,
    output in_ready, out_valid, imm, target, fmt, illegal
  );
endinterface

// File: rtl/immgen_pipe.sv
// Buffered RISC-V immediate generator. Decodes the instruction format from the opcode,
// builds the sign-extended immediate and pc-relative target on the input side, and
// queues the results in a DEPTH-entry FIFO so execute-side backpressure is absorbed.
module immgen_pipe #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  immgen_pipe_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [2:0] FmtNone = 3'd0;
  localparam logic [2:0] FmtI    = 3'd1;
  localparam logic [2:0] FmtS    = 3'd2;
  localparam logic [2:0] FmtB    = 3'd3;
  localparam logic [2:0] FmtU    = 3'd4;
  localparam logic [2:0] FmtJ    = 3'd5;

  // Decode side
  logic [31:0]     imm32;
  logic [2:0]      dec_fmt;
  logic            dec_ill;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_target;

  // FIFO storage; data needs no reset because count gates visibility
  logic [XLEN-1:0] imm_mem [DEPTH];
  logic [XLEN-1:0] tgt_mem [DEPTH];
  logic [2:0]      fmt_mem [DEPTH];
  logic            ill_mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            in_ready_q, out_valid_q;
  logic            push, pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Format decode and 32-bit immediate assembly from the opcode
  always_comb begin
    imm32   = '0;
    dec_fmt = FmtNone;
    dec_ill = 1'b0;
    case (bus.instr[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
        dec_fmt = FmtI;
        imm32   = {{20{bus.instr[31]}}, bus.instr[31:20]};
      end
      7'b0100011: begin
        dec_fmt = FmtS;
        imm32   = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FmtB;
        imm32   = {{20{bus.instr[31]}}, bus.instr[7], bus.instr[30:25], bus.instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FmtU;
        imm32   = {bus.instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FmtJ;
        imm32   = {{12{bus.instr[31]}}, bus.instr[19:12], bus.instr[20], bus.instr[30:21], 1'b0};
      end
      7'b0110011, 7'b0111011: begin
        dec_fmt = FmtNone;
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
  end

  // Sign-extend to XLEN (also extends bit 31 of U-type on RV64); carry out is dropped
  assign dec_imm    = XLEN'($signed(imm32));
  assign dec_target = bus.pc + dec_imm;

  assign push = bus.in_valid && in_ready_q && !bus.flush && !reset;
  assign pop  = out_valid_q && bus.out_ready;

  // Occupancy next-state; simultaneous push and pop leaves count unchanged
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Write the decoded entry at the tail on push
  always_ff @(posedge clk) begin
    if (push) begin
      imm_mem[wr_ptr_q] <= dec_imm;
      tgt_mem[wr_ptr_q] <= dec_target;
      fmt_mem[wr_ptr_q] <= dec_fmt;
      ill_mem[wr_ptr_q] <= dec_ill;
    end
  end

  // Pointers, count and registered flags; reset dominates flush
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q     <= count_d;
      in_ready_q  <= (count_d != CntW'(DEPTH));
      out_valid_q <= (count_d != '0);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.imm       = out_valid_q ? imm_mem[rd_ptr_q] : '0;
  assign bus.target    = out_valid_q ? tgt_mem[rd_ptr_q] : '0;
  assign bus.fmt       = out_valid_q ? fmt_mem[rd_ptr_q] : 3'd0;
  assign bus.illegal   = out_valid_q ? ill_mem[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_immgen_pipe.sv
// Scoreboard bench for immgen_pipe: directed cases followed by random traffic,
// with every head entry compared against an arithmetic reference decoder.
module tb_immgen_pipe;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  bit   mon_en = 1'b0;
  bit   acc = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  immgen_pipe_if #(.XLEN(XLEN)) bus ();

  immgen_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decoder: immediate value as a signed integer built from field weights
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [63:0] pcv);
    exp_t   e;
    longint v;
    v     = 0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
        e.fmt = 3'd1;
        v = longint'(ins[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'b0100011: begin
        e.fmt = 3'd2;
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'b1100011: begin
        e.fmt = 3'd3;
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'b0110111, 7'b0010111: begin
        e.fmt = 3'd4;
        v = longint'(ins[31:12]) * 4096;
        if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
      end
      7'b1101111: begin
        e.fmt = 3'd5;
        v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
          + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      7'b0110011, 7'b0111011: e.fmt = 3'd0;
      default: e.ill = 1'b1;
    endcase
    e.imm = 64'(v);
    e.tgt = pcv + e.imm;
    return e;
  endfunction

  // Model: track what the FIFO should hold, updated at each active edge
  always @(posedge clk) begin : model
    bit do_push, do_pop;
    do_pop  = (sb.size() != 0) && bus.out_ready;
    do_push = bus.in_valid && (sb.size() != DEPTH);
    if (reset || bus.flush) begin
      sb.delete();
      acc <= 1'b0;
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(ref_decode(bus.instr, bus.pc));
      acc <= do_push;
    end
  end

  // Monitor: compare the presented head (or idle zeros) against the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", bus.out_valid, sb.size() != 0);
      check("in_ready", bus.in_ready, sb.size() != DEPTH);
      if (sb.size() != 0) begin
        check("imm", bus.imm, sb[0].imm);
        check("target", bus.target, sb[0].tgt);
        check("fmt", bus.fmt, sb[0].fmt);
        check("illegal", bus.illegal, sb[0].ill);
      end else begin
        check("idle_imm", bus.imm, 0);
        check("idle_target", bus.target, 0);
        check("idle_fmt", bus.fmt, 0);
        check("idle_illegal", bus.illegal, 0);
      end
    end
  end

  // Offer one instruction; returns at the negedge after it was accepted
  task automatic issue(input logic [31:0] i, input logic [63:0] p);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.instr    = i;
    bus.pc       = p;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      n_checks++;
      n_errors++;
      $display("FAIL issue_timeout: instr %h not accepted after %0d cycles", i, n);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_head(input string name, input logic [63:0] imm, input logic [63:0] tgt,
                             input logic [2:0] fmt, input logic ill);
    check({name, "_valid"}, bus.out_valid, 1);
    check({name, "_imm"}, bus.imm, imm);
    check({name, "_target"}, bus.target, tgt);
    check({name, "_fmt"}, bus.fmt, fmt);
    check({name, "_illegal"}, bus.illegal, ill);
  endtask

  logic [6:0] ops [14] = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011,
                           7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                           7'b0110011, 7'b0111011, 7'b0000000, 7'b1111111};

  initial begin
    logic [31:0] r;
    logic [31:0] ins;
    int          n;
    bit          hold;

    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h0000_0013;
    bus.pc        = 64'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset held for two edges with a valid instruction offered
    @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_out_valid", bus.out_valid, 0);

    // Branch beq -4
    issue(32'hFE00_0EE3, 64'h1000);
    expect_head("beq", 64'hFFFF_FFFF_FFFF_FFFC, 64'h0FFC, 3'd3, 1'b0);

    // Store then LUI back-to-back
    issue(32'hFE11_3C23, 64'h2000);
    expect_head("sd", 64'hFFFF_FFFF_FFFF_FFF8, 64'h1FF8, 3'd2, 1'b0);
    issue(32'h8000_00B7, 64'h3000);
    expect_head("lui", 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_3000, 3'd4, 1'b0);
    check("b2b_in_ready", bus.in_ready, 1);

    // JAL wrapping below zero, then an illegal opcode
    issue(32'hFFDF_F06F, 64'h0);
    expect_head("jal", 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0);
    issue(32'h0000_007F, 64'h40);
    expect_head("illegal", 64'h0, 64'h40, 3'd0, 1'b1);
    repeat (2) @(negedge clk);

    // Backpressure: two fill the FIFO, third waits
    bus.out_ready = 1'b0;
    issue(32'h0010_0093, 64'h100);
    issue(32'h0020_0113, 64'h104);
    bus.in_valid = 1'b1;
    bus.instr    = 32'h0030_0193;
    bus.pc       = 64'h108;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
    end
    expect_head("bp_head", 64'h1, 64'h101, 3'd1, 1'b0);
    bus.out_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 20);
    check("bp_third_accepted", acc, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Flush with a full FIFO and an input offered
    bus.out_ready = 1'b0;
    issue(32'h0050_0293, 64'h200);
    issue(32'h0060_0313, 64'h204);
    bus.in_valid = 1'b1;
    bus.instr    = 32'h0070_0393;
    bus.flush    = 1'b1;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_in_ready", bus.in_ready, 1);

    // Flush with one entry, input acceptable but dropped
    issue(32'h0080_0413, 64'h300);
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h0090_0493;
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush1_out_valid", bus.out_valid, 0);
    repeat (3) @(negedge clk);

    // Random traffic; producer holds its offer until accepted or flushed
    for (int i = 0; i < 600; i++) begin
      hold = bus.in_valid && !acc && !bus.flush;
      if (!hold) begin
        r   = $urandom;
        ins = r;
        ins[6:0] = ops[$urandom_range(0, 13)];
        bus.instr    = ins;
        bus.pc       = {$urandom, $urandom};
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 29) == 0);
      @(negedge clk);
    end

    // Drain
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("drained", bus.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
